// File: rtl/game_select_arbiter_if.sv
// Game select arbiter bus bundle.
// Game-core buses in, board pins and status out.
interface game_select_arbiter_if #(
  parameter int NUM_GAMES = 2,
  parameter int LIGHT_W   = 16,
  parameter int AN_W      = 8,
  parameter int SEG_W     = 7
);
  localparam int AW = (NUM_GAMES > 1) ? $clog2(NUM_GAMES) : 1;

  logic [NUM_GAMES-1:0]         sel_req;
  logic [NUM_GAMES*LIGHT_W-1:0] game_light;
  logic [NUM_GAMES*AN_W-1:0]    game_an;
  logic [NUM_GAMES*SEG_W-1:0]   game_seg;
  logic [NUM_GAMES-1:0]         game_rst_n;
  logic [LIGHT_W-1:0]           light;
  logic [AN_W-1:0]              AN_Out;
  logic [SEG_W-1:0]             C_Out;
  logic [AW-1:0]                active_game;
  logic                         switching;

  modport master (
    output sel_req,
    output game_light,
    output game_an,
    output game_seg,
    input  game_rst_n,
    input  light,
    input  AN_Out,
    input  C_Out,
    input  active_game,
    input  switching
  );

  modport slave (
    input  sel_req,
    input  game_light,
    input  game_an,
    input  game_seg,
    output game_rst_n,
    output light,
    output AN_Out,
    output C_Out,
    output active_game,
    output switching
  );
endinterface

// File: rtl/game_select_arbiter.sv
// Selects one of NUM_GAMES game cores for the board pins.
// Blanks the display and resets the target game on each switch.
module game_select_arbiter #(
  parameter int NUM_GAMES    = 2,
  parameter int LIGHT_W      = 16,
  parameter int AN_W         = 8,
  parameter int SEG_W        = 7,
  parameter int DEFAULT_GAME = 0,
  parameter int BLANK_CYCLES = 1000,
  parameter int RST_CYCLES   = 4
) (
  input logic clock,
  input logic reset,
  game_select_arbiter_if.slave bus
);
  localparam int AW =
    (NUM_GAMES > 1) ? $clog2(NUM_GAMES) : 1;
  localparam int CMAX =
    (BLANK_CYCLES > RST_CYCLES) ? BLANK_CYCLES : RST_CYCLES;
  localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_BLANK,
    ST_RESETG
  } state_t;

  logic [NUM_GAMES-1:0] sync1_q;
  logic [NUM_GAMES-1:0] sync2_q;
  logic [NUM_GAMES-1:0] prev_q;
  logic [NUM_GAMES-1:0] req_edge;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        act_q, act_d;
  logic [AW-1:0]        pend_q, pend_d;
  logic [NUM_GAMES-1:0] rst_n_q, rst_n_d;
  logic                 switching_q;

  logic                 hit;
  logic [AW-1:0]        hit_idx;

  logic [LIGHT_W-1:0]   light_o;
  logic [AN_W-1:0]      an_o;
  logic [SEG_W-1:0]     seg_o;

  // Two-flop synchroniser plus edge history per button
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= bus.sel_req;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign req_edge = sync2_q & ~prev_q;

  // Lowest-index new press for a game other than the current one
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = NUM_GAMES - 1; k >= 0; k--) begin
      if (req_edge[k] && (AW'(k) != act_q)) begin
        hit     = 1'b1;
        hit_idx = AW'(k);
      end
    end
  end

  // FSM state, counter, selection and game reset registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_ACTIVE;
      cnt_q       <= '0;
      act_q       <= AW'(DEFAULT_GAME);
      pend_q      <= '0;
      rst_n_q     <= '0;
      switching_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      rst_n_q     <= rst_n_d;
      switching_q <= (state_d != ST_ACTIVE);
    end
  end

  // Next state: blank, then reset the target, then hand over
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    pend_d  = pend_q;
    rst_n_d = rst_n_q;
    unique case (state_q)
      ST_ACTIVE: begin
        rst_n_d = '1;
        if (hit) begin
          pend_d  = hit_idx;
          cnt_d   = CW'(BLANK_CYCLES - 1);
          state_d = ST_BLANK;
        end
      end
      ST_BLANK: begin
        if (cnt_q == '0) begin
          act_d   = pend_q;
          cnt_d   = CW'(RST_CYCLES - 1);
          rst_n_d = ~(NUM_GAMES'(1) << pend_q);
          state_d = ST_RESETG;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESETG: begin
        if (cnt_q == '0) begin
          rst_n_d = '1;
          state_d = ST_ACTIVE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        rst_n_d = '1;
        state_d = ST_ACTIVE;
      end
    endcase
  end

  // Route the active game to the pins, dark while switching
  always_comb begin
    light_o = '0;
    an_o    = '1;
    seg_o   = '1;
    if (state_q == ST_ACTIVE) begin
      for (int k = 0; k < NUM_GAMES; k++) begin
        if (AW'(k) == act_q) begin
          light_o = bus.game_light[k*LIGHT_W +: LIGHT_W];
          an_o    = bus.game_an[k*AN_W +: AN_W];
          seg_o   = bus.game_seg[k*SEG_W +: SEG_W];
        end
      end
    end
  end

  assign bus.light       = light_o;
  assign bus.AN_Out      = an_o;
  assign bus.C_Out       = seg_o;
  assign bus.game_rst_n  = rst_n_q;
  assign bus.active_game = act_q;
  assign bus.switching   = switching_q;

endmodule

// File: tb/tb_game_select_arbiter.sv
// Bench for game_select_arbiter.
// Directed scenarios then random presses vs a timeline model.
module tb_game_select_arbiter;
  localparam int NG = 3;
  localparam int LW = 16;
  localparam int AWD = 8;
  localparam int SW = 7;
  localparam int B = 4;
  localparam int R = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  game_select_arbiter_if #(
    .NUM_GAMES(NG),
    .LIGHT_W(LW),
    .AN_W(AWD),
    .SEG_W(SW)
  ) bus ();

  game_select_arbiter #(
    .NUM_GAMES(NG),
    .LIGHT_W(LW),
    .AN_W(AWD),
    .SEG_W(SW),
    .DEFAULT_GAME(0),
    .BLANK_CYCLES(B),
    .RST_CYCLES(R)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  logic [NG-1:0] hist[$];
  int e;
  int sw_start;
  int m_act;
  int m_tgt;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    repeat (4) hist.push_back('0);
    e = 0;
    sw_start = -1000;
    m_act = 0;
    m_tgt = 0;
  endtask

  task automatic model_edge(input logic [NG-1:0] s);
    logic [NG-1:0] ed;
    bit found;
    e++;
    hist.push_back(s);
    if (hist.size() > 8) hist.delete(0);
    ed = hist[hist.size()-3] & ~hist[hist.size()-4];
    found = 0;
    if ((e - 1 - sw_start) >= B + R) begin
      for (int k = 0; k < NG; k++) begin
        if (!found && ed[k] && k != m_act) begin
          found = 1;
          sw_start = e;
          m_tgt = k;
        end
      end
    end
    if (e - sw_start == B) m_act = m_tgt;
  endtask

  task automatic model_check();
    int ph;
    bit busy;
    logic [NG-1:0] er;
    logic [LW-1:0] el;
    logic [AWD-1:0] ea;
    logic [SW-1:0] es;
    ph = e - sw_start;
    busy = (ph < B + R);
    er = (e == 0) ? '0 : '1;
    if (e != 0 && busy && ph >= B) er[m_tgt] = 1'b0;
    if (busy) begin
      el = '0;
      ea = '1;
      es = '1;
    end else begin
      el = bus.game_light[m_act*LW +: LW];
      ea = bus.game_an[m_act*AWD +: AWD];
      es = bus.game_seg[m_act*SW +: SW];
    end
    chk("active", 32'(bus.active_game), m_act);
    chk("switching", 32'(bus.switching), 32'(busy));
    chk("rst_n", 32'(bus.game_rst_n), 32'(er));
    chk("light", 32'(bus.light), 32'(el));
    chk("an", 32'(bus.AN_Out), 32'(ea));
    chk("seg", 32'(bus.C_Out), 32'(es));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge(bus.sel_req);
    #1;
    model_check();
  endtask

  task automatic randg();
    bus.game_light = 48'({$urandom(), $urandom()});
    bus.game_an = 24'($urandom());
    bus.game_seg = 21'($urandom());
  endtask

  task automatic run(input int n);
    repeat (n) begin
      randg();
      step();
    end
  endtask

  task automatic pulse(input logic [NG-1:0] v);
    bus.sel_req = v;
    randg();
    step();
    bus.sel_req = '0;
  endtask

  task automatic reset_now();
    reset = 1'b0;
    #1;
    model_reset();
    model_check();
    chk("rst_low", 32'(bus.game_rst_n), 32'(3'b000));
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    bus.sel_req = '0;
    bus.game_light = '0;
    bus.game_an = '1;
    bus.game_seg = '1;
    bus.game_light[15:0] = 16'h00F0;
    reset_now();
    step();
    chk("light_init", 32'(bus.light), 32'h00F0);
    chk("rst_rel", 32'(bus.game_rst_n), 32'(3'b111));

    // single press of game 2
    bus.sel_req = 3'b100;
    step();
    bus.sel_req = '0;
    step();
    step();
    chk("sw_rise", 32'(bus.switching), 1);
    chk("dark_an", 32'(bus.AN_Out), 32'hFF);
    chk("dark_seg", 32'(bus.C_Out), 32'h7F);
    run(10);
    chk("to_g2", 32'(bus.active_game), 2);

    // simultaneous 1 and 2 from game 0
    pulse(3'b001);
    run(10);
    bus.sel_req = 3'b110;
    run(3);
    bus.sel_req = '0;
    run(10);
    chk("lowest", 32'(bus.active_game), 1);

    // same-game press, then long hold
    pulse(3'b001);
    run(10);
    pulse(3'b001);
    run(6);
    chk("same_sw", 32'(bus.switching), 0);
    bus.sel_req = 3'b010;
    run(100);
    bus.sel_req = '0;
    run(10);
    chk("held", 32'(bus.active_game), 1);

    // press during blank is dropped
    pulse(3'b001);
    run(10);
    pulse(3'b010);
    run(3);
    pulse(3'b100);
    run(12);
    chk("drop", 32'(bus.active_game), 1);

    // reset while target game is held in reset
    pulse(3'b100);
    run(6);
    chk("in_rstg", 32'(bus.game_rst_n), 32'(3'b011));
    reset_now();
    run(1);
    chk("post_rst", 32'(bus.active_game), 0);

    // random presses
    repeat (400) begin
      if ($urandom_range(0, 5) == 0)
        bus.sel_req = 3'($urandom_range(0, 7));
      else if ($urandom_range(0, 3) == 0)
        bus.sel_req = '0;
      run(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
